// File: rtl/spart_tx_external.sv
// -----------------------------------------------------------------------------
// spart_tx_external
//
// Transmit half of a simple SPART: a small byte FIFO fed over a 16-bit shared
// register bus, drained by a serial framer that emits 8N1 frames on txd
// (8E1-style frames with an even-parity bit when SPART_TX_PARITY_EN is defined).
//
// Optional feature macro: SPART_TX_PARITY_EN
//   undefined : frames are start + 8 data + stop (10 bit-times)
//   defined   : frames are start + 8 data + even parity + stop (11 bit-times)
//   The register map is identical in both builds.
//
// Parameters
//   BAUD_DIV_RST : reset value of the divisor register (clk cycles per bit)
//   FIFO_AW      : FIFO address width, depth = 2**FIFO_AW
//
// Ports
//   clk      in   1  single clock, all logic on posedge
//   rst      in   1  synchronous active-high reset
//   cs       in   1  chip select, one bus access per asserted cycle
//   we       in   1  1 = write, 0 = read (qualified by cs)
//   addr_in  in   2  register select
//   DataBus  io  16  shared data bus, driven only in the cycle after a read
//   txd      out  1  serial output, idle high
//
// Register map
//   00  W   push DataBus[7:0] into the FIFO
//   01  R   status {10'b0, ovf, count[2:0], idle, tbr}; a read clears ovf
//   10  RW  divisor (writes of 0 or 1 are stored as 2)
//   11  -   reserved, writes ignored, reads 16'h0000
//
// FSM states
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | txd high; pops the FIFO head and latches divisor if non-empty
//   START   | start bit (txd low) for one latched bit-time
//   DATA    | 8 data bits, LSB first, one bit-time each
//   PARITY  | even parity over the data byte (parity build only)
//   STOP    | stop bit (txd high), then back to IDLE
// -----------------------------------------------------------------------------
module spart_tx_external #(
    parameter logic [15:0] BAUD_DIV_RST = 16'd5208,
    parameter int          FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic [1:0]  addr_in,
    inout  wire  [15:0] DataBus,
    output logic        txd
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    localparam logic [1:0] A_PUSH   = 2'b00;
    localparam logic [1:0] A_STATUS = 2'b01;
    localparam logic [1:0] A_DIV    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef SPART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [7:0]          r_mem [DEPTH];
    logic [FIFO_AW-1:0]  r_wp;
    logic [FIFO_AW-1:0]  r_rp;
    logic [FIFO_AW:0]    r_count;
    logic                r_ovf;
    logic [15:0]         r_div;
    logic [15:0]         r_div_lat;
    logic [15:0]         r_baud;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;
    logic                r_rd_en;
    logic [15:0]         r_rd_data;
`ifdef SPART_TX_PARITY_EN
    logic                r_par;
`endif

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic                w_pop;
    logic                w_txd;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_push_ok;
    logic                w_ovf_set;
    logic                w_rd;
    logic                w_stat_rd;
    logic                w_div_wr;
    logic                w_baud_tc;
    logic                w_idle;
    logic [2:0]          w_cnt3;
    logic [15:0]         w_status;
    logic [15:0]         w_rd_mux;
    logic [15:0]         w_div_in;

    assign w_full    = (r_count == DEPTH_C);
    assign w_empty   = (r_count == '0);

    // Full is judged on the pre-cycle count, so a push into a full FIFO is
    // dropped even if the FSM pops in the same cycle.
    assign w_push    = cs & we & (addr_in == A_PUSH);
    assign w_push_ok = w_push & ~w_full;
    assign w_ovf_set = w_push & w_full;

    assign w_rd      = cs & ~we;
    assign w_stat_rd = w_rd & (addr_in == A_STATUS);
    assign w_div_wr  = cs & we & (addr_in == A_DIV);

    assign w_baud_tc = (r_baud == '0);

    assign w_idle    = w_empty & (r_state == S_IDLE);
    assign w_cnt3    = 3'(r_count);
    assign w_status  = {10'b0, r_ovf, w_cnt3, w_idle, ~w_full};

    // A bit-time below 2 cycles would break the down-counter reload.
    assign w_div_in  = (DataBus < 16'd2) ? 16'd2 : DataBus;

    always_comb begin
        w_rd_mux = 16'h0000;
        case (addr_in)
            A_STATUS: w_rd_mux = w_status;
            A_DIV:    w_rd_mux = r_div;
            default:  w_rd_mux = 16'h0000;
        endcase
    end

    assign DataBus = r_rd_en ? r_rd_data : 16'hzzzz;
    assign txd     = w_txd;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_txd       = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_txd = 1'b0;
                if (w_baud_tc) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_txd = r_shift[0];
                if (w_baud_tc && (r_bit == 3'd7)) begin
`ifdef SPART_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef SPART_TX_PARITY_EN
            S_PARITY: begin
                w_txd = r_par;
                if (w_baud_tc) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                w_txd = 1'b1;
                if (w_baud_tc) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage (contents need no reset, occupancy is tracked separately)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wp] <= DataBus[7:0];
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, status, divisor, bit timing and bus read path
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_div     <= BAUD_DIV_RST;
            r_div_lat <= BAUD_DIV_RST;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_rd_en   <= 1'b0;
            r_rd_data <= '0;
`ifdef SPART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            if (w_push_ok) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
                default: r_count <= r_count;
            endcase

            // A same-cycle overflow wins over the clear-on-read.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_stat_rd) begin
                r_ovf <= 1'b0;
            end

            if (w_div_wr) begin
                r_div <= w_div_in;
            end

            // The divisor is captured at pop time so a write mid-frame only
            // affects the following frame.
            if (w_pop) begin
                r_shift   <= r_mem[r_rp];
                r_div_lat <= r_div;
                r_baud    <= r_div - 16'd1;
                r_bit     <= '0;
`ifdef SPART_TX_PARITY_EN
                r_par     <= ^r_mem[r_rp];
`endif
            end else if (r_state != S_IDLE) begin
                if (w_baud_tc) begin
                    r_baud <= r_div_lat - 16'd1;
                    if (r_state == S_DATA) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                    end
                end else begin
                    r_baud <= r_baud - 16'd1;
                end
            end

            r_rd_en <= w_rd;
            if (w_rd) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_spart_tx_external.sv
module tb_spart_tx_external;

`ifdef SPART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // The bench pulls the bus up, so a released bus reads as all ones.
    localparam logic [15:0] BUS_REL = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        we;
    logic [1:0]  addr_in;
    wire  [15:0] DataBus;
    logic        txd;
    logic        tb_drv;
    logic [15:0] tb_bus;

    int          checks   = 0;
    int          failures = 0;
    int          mon_div  = 4;
    logic [7:0]  rx_q [$];
    logic [7:0]  rx_b;

    always #5 clk = ~clk;

    assign DataBus = tb_drv ? tb_bus : 16'hzzzz;

    for (genvar gi = 0; gi < 16; gi++) begin : g_pu
        pullup (DataBus[gi]);
    end

    spart_tx_external #(
        .BAUD_DIV_RST (16'd5208),
        .FIFO_AW      (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .we      (we),
        .addr_in (addr_in),
        .DataBus (DataBus),
        .txd     (txd)
    );

    // Serial receiver model: detects the start bit, samples mid-bit.
    initial begin
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (mon_div / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clk);
                    rx_b[i] = txd;
                end
                repeat (mon_div * (NBITS - 9)) @(negedge clk);
                rx_q.push_back(rx_b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected line levels for one frame, bit 0 first.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef SPART_TX_PARITY_EN
        f[9]   = ^b;
        f[10]  = 1'b1;
`else
        f[9]   = 1'b1;
`endif
        return f;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cs = 1'b1; we = 1'b1; addr_in = a; tb_bus = d; tb_drv = 1'b1;
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        cs = 1'b1; we = 1'b0; addr_in = a;
        @(posedge clk);
        #1;
        cs = 1'b0;
        d = DataBus;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        repeat (2) cyc();
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL rst_txd got=%b exp=1", txd); end
        rst = 1'b0;
        checks++; if (DataBus !== BUS_REL) begin failures++; $display("FAIL rst_bus_released got=%h exp=%h", DataBus, BUS_REL); end
        rd(2'b01, d);
        checks++; if (d !== 16'h0003) begin failures++; $display("FAIL rst_status got=%h exp=0003", d); end
        cyc();
        checks++; if (DataBus !== BUS_REL) begin failures++; $display("FAIL rst_status_release got=%h exp=%h", DataBus, BUS_REL); end
        rd(2'b10, d);
        checks++; if (d !== 16'd5208) begin failures++; $display("FAIL rst_divisor got=%h exp=%h", d, 16'd5208); end
        rd(2'b11, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rst_reserved got=%h exp=0000", d); end
        cyc();
    endtask

    task automatic test_divisor();
        logic [15:0] d;
        wr(2'b10, 16'h0000);
        rd(2'b10, d);
        checks++; if (d !== 16'h0002) begin failures++; $display("FAIL div_zero got=%h exp=0002", d); end
        cyc();
        wr(2'b10, 16'h0001);
        rd(2'b10, d);
        checks++; if (d !== 16'h0002) begin failures++; $display("FAIL div_one got=%h exp=0002", d); end
        cyc();
        wr(2'b10, 16'h1234);
        rd(2'b10, d);
        checks++; if (d !== 16'h1234) begin failures++; $display("FAIL div_plain got=%h exp=1234", d); end
        cyc();
        wr(2'b11, 16'hFFFF);
        rd(2'b11, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reserved_read got=%h exp=0000", d); end
        rd(2'b10, d);
        checks++; if (d !== 16'h1234) begin failures++; $display("FAIL reserved_no_side_effect got=%h exp=1234", d); end
        cyc();
    endtask

    task automatic test_single_frame();
        logic [10:0] f;
        logic        e;
        f = frame_bits(8'hA5);
        wr(2'b10, 16'd4);
        wr(2'b00, 16'h00A5);
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL a5_txd_n1 got=%b exp=1", txd); end
        cyc();
        for (int k = 0; k < NBITS * 4; k++) begin
            e = f[k / 4];
            checks++; if (txd !== e) begin failures++; $display("FAIL a5_frame cyc=%0d got=%b exp=%b", k, txd, e); end
            cyc();
        end
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL a5_idle_after got=%b exp=1", txd); end
        repeat (4) cyc();
        rx_q.delete();
    endtask

    task automatic test_push_visibility();
        logic [15:0] d;
        logic [7:0]  got;
        rx_q.delete();
        wr(2'b00, 16'h003C);
        rd(2'b01, d);
        checks++; if (d !== 16'h0005) begin failures++; $display("FAIL push_count_n1 got=%h exp=0005", d); end
        cyc();
        checks++; if (DataBus !== BUS_REL) begin failures++; $display("FAIL push_bus_release got=%h exp=%h", DataBus, BUS_REL); end
        for (int i = 0; i < 200 && rx_q.size() < 1; i++) cyc();
        got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        checks++; if (got !== 8'h3C) begin failures++; $display("FAIL push_rx_byte got=%h exp=3c", got); end
        repeat (6) cyc();
        rd(2'b01, d);
        checks++; if (d !== 16'h0003) begin failures++; $display("FAIL push_status_idle got=%h exp=0003", d); end
        cyc();
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        logic [7:0]  got;
        rx_q.delete();
        for (int i = 1; i <= 6; i++) wr(2'b00, 16'(i));
        rd(2'b01, d);
        checks++; if (d !== 16'h0030) begin failures++; $display("FAIL ovf_status_first got=%h exp=0030", d); end
        rd(2'b01, d);
        checks++; if (d !== 16'h0010) begin failures++; $display("FAIL ovf_status_second got=%h exp=0010", d); end
        cyc();
        for (int i = 0; i < 600 && rx_q.size() < 5; i++) cyc();
        checks++; if (rx_q.size() != 5) begin failures++; $display("FAIL ovf_rx_count got=%0d exp=5", rx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++; if (got !== 8'(i + 1)) begin failures++; $display("FAIL ovf_rx_order idx=%0d got=%h exp=%h", i, got, 8'(i + 1)); end
        end
        repeat (60) cyc();
        checks++; if (rx_q.size() != 5) begin failures++; $display("FAIL ovf_dropped_byte got=%0d frames exp=5", rx_q.size()); end
        rd(2'b01, d);
        checks++; if (d !== 16'h0003) begin failures++; $display("FAIL ovf_status_final got=%h exp=0003", d); end
        cyc();
    endtask

    task automatic test_div_midframe();
        logic [15:0] d;
        logic [10:0] f1;
        logic [10:0] f2;
        logic        e;
        f1 = frame_bits(8'h5A);
        f2 = frame_bits(8'hC3);
        wr(2'b10, 16'd4);
        wr(2'b00, 16'h005A);
        wr(2'b00, 16'h00C3);
        for (int k = 0; k < NBITS * 4; k++) begin
            e = f1[k / 4];
            checks++; if (txd !== e) begin failures++; $display("FAIL divmid_frame1 cyc=%0d got=%b exp=%b", k, txd, e); end
            if (k == 10) wr(2'b10, 16'd8);
            else cyc();
        end
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL divmid_gap got=%b exp=1", txd); end
        cyc();
        for (int k = 0; k < NBITS * 8; k++) begin
            e = f2[k / 8];
            checks++; if (txd !== e) begin failures++; $display("FAIL divmid_frame2 cyc=%0d got=%b exp=%b", k, txd, e); end
            cyc();
        end
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL divmid_idle_after got=%b exp=1", txd); end
        rd(2'b10, d);
        checks++; if (d !== 16'd8) begin failures++; $display("FAIL divmid_readback got=%h exp=0008", d); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [10:0] f1;
        logic [10:0] f2;
        logic        e;
        f1 = frame_bits(8'h96);
        f2 = frame_bits(8'h69);
        wr(2'b10, 16'd3);
        wr(2'b00, 16'h0096);
        wr(2'b00, 16'h0069);
        for (int k = 0; k < NBITS * 3; k++) begin
            e = f1[k / 3];
            checks++; if (txd !== e) begin failures++; $display("FAIL b2b_frame1 cyc=%0d got=%b exp=%b", k, txd, e); end
            cyc();
        end
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL b2b_idle_gap got=%b exp=1", txd); end
        cyc();
        for (int k = 0; k < NBITS * 3; k++) begin
            e = f2[k / 3];
            checks++; if (txd !== e) begin failures++; $display("FAIL b2b_frame2 cyc=%0d got=%b exp=%b", k, txd, e); end
            cyc();
        end
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL b2b_idle_after got=%b exp=1", txd); end
        repeat (3) cyc();
    endtask

    task automatic test_reset_midframe();
        logic [15:0] d;
        int          lows;
        wr(2'b10, 16'd4);
        wr(2'b00, 16'h00FF);
        wr(2'b00, 16'h0011);
        wr(2'b00, 16'h0022);
        repeat (10) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL rstmid_txd got=%b exp=1", txd); end
        checks++; if (DataBus !== BUS_REL) begin failures++; $display("FAIL rstmid_bus got=%h exp=%h", DataBus, BUS_REL); end
        rd(2'b01, d);
        checks++; if (d !== 16'h0003) begin failures++; $display("FAIL rstmid_status got=%h exp=0003", d); end
        rd(2'b10, d);
        checks++; if (d !== 16'd5208) begin failures++; $display("FAIL rstmid_divisor got=%h exp=%h", d, 16'd5208); end
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            cyc();
            if (txd !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin failures++; $display("FAIL rstmid_no_frames got=%0d low cycles exp=0", lows); end
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; we = 1'b0; addr_in = 2'b00;
        tb_drv = 1'b0; tb_bus = 16'h0000;
        test_reset();
        test_divisor();
        test_single_frame();
        test_push_visibility();
        test_overflow();
        test_div_midframe();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
